// File: rtl/nn_pkg.sv
// Shared definitions for the layer-result datapath: default widths,
// the result-reader state encoding and the signed result word type.
package nn_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 16;

  // Reader controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Signed two's complement result word shared with argmax and layer blocks.
  typedef logic signed [DEF_DATA_WIDTH-1:0] result_word_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO holding packed {data, index, last} beats between the
// RAM read return and the output stream. The caller guarantees it never
// pushes when full and never pops when empty.
module stream_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage slots, pointers and occupancy update on push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) begin
          slot1 <= push_data;
        end else begin
          slot0 <= push_data;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = rd_ptr ? slot1 : slot0;

endmodule

// File: rtl/result_stream_reader.sv
// Reads `size` result words from a synchronous RAM starting at base_addr
// and presents them in order as a valid/ready stream tagged with index and
// last, then pulses done.
//
// Stream handshake: a beat transfers on every cycle where out_valid and
// out_ready are both high; once out_valid is raised, out_data, out_index and
// out_last hold stable until that transfer happens.
//
// The word coming back from the RAM is forwarded straight to the output when
// the skid FIFO is empty, so the first word is visible the cycle after the
// first read. If it is not taken that cycle it drops into the FIFO, whose
// head then shows the same beat. Reads are throttled so that the words in
// flight plus the words buffered never exceed two.
module result_stream_reader
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] size,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output state_e                state
);

  localparam int PW = DATA_WIDTH + ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] size_q;
  logic [ADDR_WIDTH-1:0] issued;
  logic [ADDR_WIDTH-1:0] received;
  logic                  rd_pending;
  logic                  ret_last;
  logic [PW-1:0]         ret_beat;
  logic [PW-1:0]         head_beat;
  logic [1:0]            fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  pop;
  logic [2:0]            committed;
  logic                  credit_ok;

  // Tag the returning word with its element index and last flag.
  assign ret_last = (received == size_q - 1'b1);
  assign ret_beat = {mem_rdata, received, ret_last};

  assign fifo_empty = (fifo_count == 2'd0);
  assign out_valid  = !fifo_empty || rd_pending;
  assign pop        = out_valid && out_ready;

  // Returning data bypasses the FIFO only when it is consumed immediately.
  assign fifo_push = rd_pending && !(fifo_empty && out_ready);
  assign fifo_pop  = pop && !fifo_empty;

  // Words committed to the buffer after this cycle if another read were
  // not issued: read in progress + word returning + buffered - word leaving.
  assign committed = {2'b00, mem_rd_en} + {2'b00, rd_pending}
                   + {1'b0, fifo_count} - {2'b00, pop};
  assign credit_ok = (committed < 3'd2);

  stream_skid_fifo #(
    .WIDTH (PW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (ret_beat),
    .pop       (fifo_pop),
    .head_data (head_beat),
    .count     (fifo_count)
  );

  // Output mux: FIFO head when buffered, else the bypassed RAM word, else zero.
  always_comb begin
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (!fifo_empty) begin
      {out_data, out_index, out_last} = head_beat;
    end else if (rd_pending) begin
      {out_data, out_index, out_last} = ret_beat;
    end
  end

  // RAM data arrives one cycle after the read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= mem_rd_en;
    end
  end

  // Count returned words; this becomes the index tag of the next return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      received <= '0;
    end else if (state == S_IDLE && start) begin
      received <= '0;
    end else if (rd_pending) begin
      received <= received + 1'b1;
    end
  end

  // Controller FSM: latches the request, issues credited reads, waits for
  // the last beat to leave, then pulses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      base_q    <= '0;
      size_q    <= '0;
      issued    <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            size_q <= size;
            busy   <= 1'b1;
            if (size == '0) begin
              issued <= '0;
              state  <= S_DONE;
            end else begin
              // The first read needs no credit: everything is empty.
              mem_rd_en <= 1'b1;
              mem_addr  <= base_addr;
              issued    <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (issued == size_q) begin
            state <= S_DRAIN;
          end else if (credit_ok) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= base_q + issued;
            issued    <= issued + 1'b1;
          end
        end
        S_DRAIN: begin
          if (pop && out_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Arriving from DRAIN, done is already up: finish. Arriving from an
          // empty request, raise done here for its single cycle first.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/result_stream_reader.md
Name: result_stream_reader

Overview:
- Producer end of the layer-result interface that argmax-style consumers read.
- On start, reads `size` signed 32-bit words from a synchronous result RAM, beginning at `base_addr`.
- Presents the words in order as a valid/ready stream, each tagged with its element index and a last flag, then pulses done.
- Sits between a layer's output buffer and any sequential consumer (argmax, softmax, debug dump).

Parameters:
- DATA_WIDTH, 32, width of a result word (signed, two's complement; passed through untouched).
- ADDR_WIDTH, 16, width of RAM address, base_addr, size and out_index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first RAM address; latched on accepted start.
- size  in  ADDR_WIDTH  element count; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_rdata  in  DATA_WIDTH  RAM data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  out_data/out_index/out_last valid.
- out_ready  in  1  consumer accepts the current word.
- out_data  out  DATA_WIDTH  result word.
- out_index  out  ADDR_WIDTH  element index, 0..size-1.
- out_last  out  1  high with the final element (index size-1).

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=IDLE.
  - busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0.
  - Issue counter, delivered counter and buffer occupancy all cleared.
- Reset mid-transfer aborts immediately. No done pulse is produced and buffered data is discarded.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr and size and clears the counters.
  - If size==0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - mem_rd_en=1 with mem_addr=base+issued when credit allows. Credit condition: in-flight read + buffered words - (pop this cycle) < 2.
  - issued increments on each read.
  - When issued reaches size, go to DRAIN.
- DRAIN: no further reads. Go to DONE on the cycle the final word (out_last) handshakes.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start is ignored outside IDLE, including in the DONE cycle.
- Read data buffering:
  - Returning mem_rdata is written into a 2-entry FIFO (skid buffer).
  - The head drives out_data, out_index and out_last.
  - Pop occurs when out_valid && out_ready.
  - The FIFO never overflows; the credit rule guarantees it.
- Timing with out_ready held high:
  - start at cycle 0 → mem_rd_en/mem_addr=base at cycle 1 → out_valid with mem[base], index 0 at cycle 2.
  - Throughput is then 1 word/cycle.
  - For size N, the last handshake is at cycle N+1 and done=1 at cycle N+2.
- Backpressure:
  - While out_ready=0, out_valid/out_data/out_index/out_last hold stable.
  - Reads stall once 2 words are outstanding.
  - Deasserting and reasserting out_ready loses and duplicates no data.
- Address arithmetic: mem_addr = base_addr + issued, modulo 2^ADDR_WIDTH. Wrap from 0xFFFF to 0x0000 is legal.
- out_index counts 0..size-1 independent of base_addr.
- size = 2^ADDR_WIDTH - 1 must work: counters are ADDR_WIDTH bits and the compare is exact.
- out_last is asserted only with index size-1. With size==1 it is high on index 0.
- mem_addr holds its last value when mem_rd_en=0.

Decomposition:
- Shared package nn_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - State enum (IDLE, ISSUE, DRAIN, DONE).
  - A typedef for the signed result word, reused by argmax and the layer blocks.
- One sub-module is natural: stream_skid_fifo, a 2-entry FIFO carrying {data, index, last} with push/pop/count outputs.
- The controller owns the credit logic and counters.

Test Plan:
- base=0x0010, size=10, RAM[0x10+i]=i*100-450, out_ready=1:
  - Words −450..450 with indices 0..9, one per cycle from cycle 2.
  - out_last only on index 9; done at cycle 12.
- size=0, start → no mem_rd_en, no out_valid, done=1 exactly at cycle 2.
- base=0xFFFE, size=4 → mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; data order preserved.
- size=10 with out_ready toggling 1,0,0,1,0,1… (random seed) → consumer receives exactly 10 words in order with no duplicates. Outputs stable during stalls; at most 2 reads outstanding.
- start pulsed again at cycles 3 and 12 (during run and the done cycle) → ignored; a single transfer with a single done.
- rst_n asserted at cycle 5 of a size=10 run → all outputs 0 asynchronously. A fresh start after release transfers from index 0 correctly.
